ram_sp_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port synchronous-read/write RAM (registered read data, bidirectional tri-state data bus, cs/we/oe controls).
- Accepts read/write commands from two clients, grants one at a time round-robin, and drives the RAM pins with correct read/write timing.
- Owns the shared data bus and drives it only during writes; returns read data with a valid pulse.

---
 rtl/ram_sp_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ram_sp_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_arbiter.sv
// Two-client round-robin arbiter and sequencer for a single-port synchronous RAM with a tri-state data bus.
// Define RAM_ARB_FIXED_PRI_EN to replace round-robin with fixed priority (client 0 wins conflicts).
module ram_sp_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);

   typedef enum logic [1:0] {IDLE, WRITE, READ1, READ2} state_t;

   state_t                state_q, state_d;
   logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic                  cs_q, cs_d, we_q, we_d, oe_q, oe_d;
   logic                  owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  pick1;
   logic                  sel_we;
`ifndef RAM_ARB_FIXED_PRI_EN
   // prio_q = 1 means client 1 wins the next conflict
   logic                  prio_q, prio_d;
`endif

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign rvalid0     = rvalid0_q;
   assign rvalid1     = rvalid1_q;
   assign rdata       = rdata_q;
   assign ram_cs      = cs_q;
   assign ram_we      = we_q;
   assign ram_oe      = oe_q;
   assign ram_address = addr_q;
   assign ram_data    = (cs_q && we_q) ? wdata_q : {DATA_WIDTH{1'bz}};

   always_comb begin
      state_d   = state_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      cs_d      = cs_q;
      we_d      = we_q;
      oe_d      = oe_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      pick1     = 1'b0;
      sel_we    = 1'b0;
`ifndef RAM_ARB_FIXED_PRI_EN
      prio_d    = prio_q;
`endif
      case (state_q)
         IDLE: begin
            cs_d = 1'b0;
            we_d = 1'b0;
            oe_d = 1'b0;
            if (req0 || req1) begin
`ifdef RAM_ARB_FIXED_PRI_EN
               pick1  = req1 && !req0;
`else
               pick1  = req1 && (!req0 || prio_q);
               prio_d = !pick1;
`endif
               sel_we  = pick1 ? we1 : we0;
               gnt0_d  = !pick1;
               gnt1_d  = pick1;
               owner_d = pick1;
               addr_d  = pick1 ? addr1 : addr0;
               wdata_d = pick1 ? wdata1 : wdata0;
               cs_d    = 1'b1;
               we_d    = sel_we;
               oe_d    = !sel_we;
               state_d = sel_we ? WRITE : READ1;
            end
         end
         WRITE: begin
            cs_d    = 1'b0;
            we_d    = 1'b0;
            oe_d    = 1'b0;
            state_d = IDLE;
         end
         READ1: begin
            state_d = READ2;
         end
         READ2: begin
            // RAM is driving its registered word onto the bus this cycle
            rdata_d   = ram_data;
            rvalid0_d = !owner_q;
            rvalid1_d = owner_q;
            cs_d      = 1'b0;
            we_d      = 1'b0;
            oe_d      = 1'b0;
            state_d   = IDLE;
         end
         default: begin
            cs_d    = 1'b0;
            we_d    = 1'b0;
            oe_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         cs_q      <= 1'b0;
         we_q      <= 1'b0;
         oe_q      <= 1'b0;
         owner_q   <= 1'b0;
         addr_q    <= '0;
         rdata_q   <= '0;
`ifndef RAM_ARB_FIXED_PRI_EN
         prio_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         cs_q      <= cs_d;
         we_q      <= we_d;
         oe_q      <= oe_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         rdata_q   <= rdata_d;
`ifndef RAM_ARB_FIXED_PRI_EN
         prio_q    <= prio_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      wdata_q <= wdata_d;
   end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed bench for ram_sp_arbiter with a behavioural single-port RAM on the tri-state bus.
module tb_ram_sp_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1, we0, we1;
   logic [3:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] rdata;
   logic [3:0] ram_address;
   logic       ram_cs, ram_we, ram_oe;
   wire  [7:0] ram_data;

   int n_vec  = 0;
   int n_miss = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   ram_sp_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .ram_address(ram_address), .ram_cs(ram_cs), .ram_we(ram_we),
      .ram_oe(ram_oe), .ram_data(ram_data)
   );

   // RAM model: registered read, drives the bus while selected for reading
   logic [7:0] mem [16];
   logic [7:0] ram_rd_q;
   logic       ram_drv;
   assign ram_drv  = ram_cs && ram_oe && !ram_we;
   assign ram_data = ram_drv ? ram_rd_q : 8'hzz;
   always @(posedge clk) begin
      if (ram_cs && ram_we) mem[ram_address] <= ram_data;
      if (ram_cs && !ram_we) ram_rd_q <= mem[ram_address];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("we_oe_excl", {31'd0, ram_we && ram_oe}, 32'd0);
         if (!ram_we && !ram_drv) check("bus_z", {31'd0, ram_data === 8'hzz}, 32'd1);
         if (ram_drv) check("bus_rd_clean", {31'd0, ram_data === ram_rd_q}, 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic c, input logic [3:0] a, input logic [7:0] exp);
      if (c) begin req1 = 1'b1; we1 = 1'b0; addr1 = a; end
      else   begin req0 = 1'b1; we0 = 1'b0; addr0 = a; end
      tick();
      check("rd_gnt0", {31'd0, gnt0}, {31'd0, !c});
      check("rd_gnt1", {31'd0, gnt1}, {31'd0, c});
      check("rd_addr", {28'd0, ram_address}, {28'd0, a});
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      check("rd_wait_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
      tick();
      check("rd_rv0", {31'd0, rvalid0}, {31'd0, !c});
      check("rd_rv1", {31'd0, rvalid1}, {31'd0, c});
      check("rd_data", {24'd0, rdata}, {24'd0, exp});
      tick();
      check("rd_rv_end", {30'd0, rvalid1, rvalid0}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      tick();
      tick();
      // reset state
      check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      check("rst_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
      check("rst_rdata", {24'd0, rdata}, 32'd0);
      check("rst_ctl", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
      check("rst_addr", {28'd0, ram_address}, 32'd0);
      check("rst_bus_z", {31'd0, ram_data === 8'hzz}, 32'd1);
      mon_en = 1'b1;

      // single write A5 -> addr 3
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 8'hA5;
      tick();
      check("w_gnt0", {31'd0, gnt0}, 32'd1);
      check("w_gnt1", {31'd0, gnt1}, 32'd0);
      check("w_ctl", {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
      check("w_addr", {28'd0, ram_address}, 32'h3);
      check("w_bus", {24'd0, ram_data}, 32'hA5);
      req0 = 1'b0;
      tick();
      check("w_end_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      check("w_end_ctl", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
      check("w_end_rv", {30'd0, rvalid1, rvalid0}, 32'd0);

      // client 1 reads it back
      do_read(1'b1, 4'h3, 8'hA5);

      // simultaneous writes right after reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h1; wdata0 = 8'h11;
      req1 = 1'b1; we1 = 1'b1; addr1 = 4'h2; wdata1 = 8'h22;
      tick();
      check("ww_gnt0", {30'd0, gnt1, gnt0}, 32'b01);
      check("ww_bus0", {24'd0, ram_data}, 32'h11);
      req0 = 1'b0;
      tick();
      check("ww_gap", {30'd0, gnt1, gnt0}, 32'd0);
      tick();
      check("ww_gnt1", {30'd0, gnt1, gnt0}, 32'b10);
      check("ww_addr1", {28'd0, ram_address}, 32'h2);
      check("ww_bus1", {24'd0, ram_data}, 32'h22);
      req1 = 1'b0;
      tick();
      do_read(1'b0, 4'h1, 8'h11);
      do_read(1'b1, 4'h2, 8'h22);

      // both clients read continuously
      req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
      for (int k = 0; k < 4; k++) begin
         logic c;
`ifdef RAM_ARB_FIXED_PRI_EN
         c = 1'b0;
`else
         c = k[0];
`endif
         tick();
         check("rr_gnt", {30'd0, gnt1, gnt0}, c ? 32'b10 : 32'b01);
         tick();
         tick();
         check("rr_rv", {30'd0, rvalid1, rvalid0}, c ? 32'b10 : 32'b01);
         check("rr_data", {24'd0, rdata}, c ? 32'h22 : 32'h11);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      tick();

      // reset during READ1
      req0 = 1'b1; we0 = 1'b0; addr0 = 4'h3;
      tick();
      check("ab_gnt0", {31'd0, gnt0}, 32'd1);
      check("ab_ctl", {29'd0, ram_cs, ram_we, ram_oe}, 32'b101);
      req0 = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("ab_cs", {31'd0, ram_cs}, 32'd0);
      check("ab_ctl0", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
      check("ab_rv_a", {30'd0, rvalid1, rvalid0}, 32'd0);
      tick();
      check("ab_rv_b", {30'd0, rvalid1, rvalid0}, 32'd0);
      check("ab_idle_cs", {31'd0, ram_cs}, 32'd0);
      tick();
      check("ab_rv_c", {30'd0, rvalid1, rvalid0}, 32'd0);
      do_read(1'b0, 4'h3, 8'hA5);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
